rv32m_divider: RTL and testbench
================================

# rv32m_divider

Iterative radix-2 restoring divider implementing RV32M DIV, DIVU, REM and REMU for the M-extension execute stage. It is the inverse partner of the single-cycle array multiplier: multiply completes in one registered cycle, while divide runs as a multi-cycle unit behind a start/done handshake. The pipeline stalls on `busy`.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request a divide; sampled only in IDLE.
- `op` in 2: operation select; 2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU.
- `a` in 32: dividend (rs1); sampled on the accepted `start`.
- `b` in 32: divisor (rs2); sampled on the accepted `start`.
- `flush` in 1: abort any in-flight operation (pipeline squash).
- `busy` out 1: high from the cycle after an accepted `start` through the cycle `done` is high.
- `done` out 1: single-cycle pulse; `result` is valid in that cycle.
- `result` out 32: quotient (DIV/DIVU) or remainder (REM/REMU).

## Operation
- States:
  - IDLE: accepts `start`; on acceptance latches operands, op, |a|, |b| and sign flags.
  - DIVIDE: 32 iterations.
  - FIXUP: applies signs and selects quotient or remainder.
  - DONE: drives `done`, then returns to IDLE.
- Transitions:
  - IDLE -> DIVIDE on `start`.
  - DIVIDE -> FIXUP when the 5-bit iteration counter reaches 31.
  - FIXUP -> DONE.
  - DONE -> IDLE unconditionally.
- Signed ops (DIV/REM):
  - Operands are converted to magnitude; 0x80000000 is treated as unsigned 2^31.
  - Quotient is negated iff sign(a) != sign(b) and b != 0.
  - Remainder takes the sign of a.
- Iteration:
  - {rem, quo} shifts left one bit.
  - Trial = rem - divisor, computed 33 bits wide.
  - If the trial is non-negative, rem = trial and quo[0] = 1; otherwise quo[0] = 0.
- Divide by zero:
  - Quotient = 0xFFFFFFFF for both signed and unsigned.
  - Remainder = a, unmodified.
- Signed overflow (a = 0x80000000, b = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- `start` while not in IDLE is ignored; there is no queuing.
- `start` asserted in the DONE cycle is ignored; the earliest re-acceptance is the following IDLE cycle.
- `result` holds its value after `done` until the next `done`.
- `flush`:
  - Forces IDLE on the next edge from any state and suppresses `done`.
  - `result` is not updated.
  - `flush` together with `start` in IDLE: the start is dropped.
- `rst` mid-operation: immediately returns to IDLE; no `done` is produced.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0x00000000, counter 0.
- Normal latency:
  - `start` accepted at edge N.
  - `busy` is high in cycles N+1 .. N+34.
  - `done` is high in cycle N+34.
- Throughput: one operation per 35 cycles.
- All outputs are registered; there is no combinational path from `a`, `b` or `op` to `result`.
- `busy` deasserts in the cycle after `done`.

## Configuration
- `RV32M_DIV_EARLY_OUT_EN` defined:
  - Divide-by-zero and signed overflow are detected in IDLE on `start`.
  - The FSM goes directly to DONE, so `done` is asserted at N+1 and `busy` is high only in cycle N+1.
  - Results are the same special values.
- `RV32M_DIV_EARLY_OUT_EN` undefined:
  - Every operation takes the full 34-cycle path.
  - The special values fall out of the iteration and FIXUP logic.
  - Results are bit-identical to the defined case.

## Test plan
- DIVU a=100, b=7 -> `done` at N+34, result=14; REMU with the same operands -> result=2.
- DIV a=0xFFFFFF9C (-100), b=7 -> result=0xFFFFFFF2 (-14); REM with the same operands -> 0xFFFFFFFE (-2).
- DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000; REM with the same operands -> 0x00000000. With the macro defined, `done` at N+1.
- DIVU a=0x12345678, b=0 -> result=0xFFFFFFFF; REMU -> 0x12345678. Check latency 1 with the macro and 34 without.
- `start` DIVU 100/7, assert `flush` at N+10, then `start` DIVU 9/3 at N+12 -> no `done` for the first operation; `done` at N+12+34 with result=3; `result` held at its prior value in between.
- Assert `rst` at N+20 of an operation -> `busy`=0, `done`=0, `result`=0 immediately; the next `start` completes normally.

Source files
------------

// File: rtl/rv32m_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle behind a start/done handshake.
// Optional macro RV32M_DIV_EARLY_OUT_EN short-circuits divide-by-zero and signed overflow straight to DONE.
module rv32m_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] div_q, div_d;
    logic        rem_sel_q, rem_sel_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_shift;
    logic [33:0] trial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
`ifdef RV32M_DIV_EARLY_OUT_EN
    logic        div_zero;
    logic        overflow;
`endif

    // Magnitude conversion: 0x80000000 negates to itself, which reads as unsigned 2^31.
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[31];
    assign b_neg     = signed_op & b[31];
    assign a_mag     = a_neg ? (~a + 32'd1) : a;
    assign b_mag     = b_neg ? (~b + 32'd1) : b;

    assign rem_shift = {rem_q, quo_q[31]};
    assign trial     = {1'b0, rem_shift} - {2'b00, div_q};

    assign quo_fix   = quo_neg_q ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix   = rem_neg_q ? (~rem_q + 32'd1) : rem_q;

`ifdef RV32M_DIV_EARLY_OUT_EN
    assign div_zero  = (b == 32'd0);
    assign overflow  = signed_op & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        rem_sel_d = rem_sel_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d     = 32'd0;
                    quo_d     = a_mag;
                    div_d     = b_mag;
                    cnt_d     = 5'd0;
                    rem_sel_d = op[1];
                    quo_neg_d = (a_neg ^ b_neg) & (b != 32'd0);
                    rem_neg_d = a_neg;
                    state_d   = S_DIVIDE;
`ifdef RV32M_DIV_EARLY_OUT_EN
                    if (div_zero || overflow) begin
                        state_d = S_DONE;
                        if (div_zero) begin
                            result_d = op[1] ? a : 32'hFFFF_FFFF;
                        end else begin
                            result_d = op[1] ? 32'd0 : 32'h8000_0000;
                        end
                    end
`endif
                end
            end
            S_DIVIDE: begin
                // Divide-by-zero needs no special case: every trial succeeds,
                // giving all-ones quotient and the dividend magnitude as remainder.
                if (!trial[33]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                result_d = rem_sel_q ? rem_fix : quo_fix;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A squash wins over everything, including a same-cycle start or result write.
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = 5'd0;
            result_d = result_q;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            div_q     <= 32'd0;
            rem_sel_q <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            rem_sel_q <= rem_sel_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_rv32m_divider.sv
// Directed testbench for rv32m_divider: arithmetic vectors, special cases, latency, flush and reset behaviour.
module tb_rv32m_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks;
    int          failures;
    logic [31:0] last_exp;
    int          early_done;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int LAT_FULL = 34;
`ifdef RV32M_DIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 1;
`else
    localparam int LAT_SPECIAL = 34;
`endif

    rv32m_divider dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Polls from cycle N+1 (start accepted at edge N) for done, checking result, latency and busy drop.
    task automatic wait_done(input string tag, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, " busy@N+1"}, {31'd0, busy}, 32'd1);
            if (done === 1'b1 && lat < 0) begin
                lat = k;
                check({tag, " result"}, result, exp_r);
            end else if (lat > 0 && k == lat + 1) begin
                check({tag, " busy after done"}, {31'd0, busy}, 32'd0);
                check({tag, " done pulse"}, {31'd0, done}, 32'd0);
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        last_exp = exp_r;
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_r, input int exp_lat);
        @(negedge clk);
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(tag, exp_r, exp_lat);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last_exp = 32'd0;
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'b00;
        a        = 32'd0;
        b        = 32'd0;

        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;

        do_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_FULL);
        do_op("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, LAT_FULL);
        do_op("DIV -100/7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, LAT_FULL);
        do_op("REM -100/7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT_FULL);
        do_op("DIV 100/-7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT_FULL);
        do_op("REM 100/-7", OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, LAT_FULL);
        do_op("DIVU big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, LAT_FULL);
        do_op("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL);
        do_op("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_SPECIAL);
        do_op("DIV -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL);
        do_op("REM -5/0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_SPECIAL);
        do_op("DIVU x/0", OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL);
        do_op("REMU x/0", OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, LAT_SPECIAL);

        // Flush mid-operation: first op never completes, result keeps the REMU x/0 value.
        @(negedge clk);
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        early_done = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) early_done++;
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        check("flush result held", result, last_exp);
        check("flush no early done", early_done, 32'd0);
        do_op("DIVU 9/3 after flush", OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_FULL);

        // Start together with flush in IDLE is dropped.
        @(negedge clk);
        op    = OP_DIVU;
        a     = 32'd50;
        b     = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush+start busy", {31'd0, busy}, 32'd0);
        check("flush+start result", result, 32'd3);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("REMU 9/4 after rst", OP_REMU, 32'd9, 32'd4, 32'd1, LAT_FULL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
